// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding, parity-type constants and parity helper
// for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   // x is the XOR reduction of the data word
   function automatic logic parity_of(input logic x, input logic typ);
      return (typ == PAR_ODD) ? ~x : x;
   endfunction
endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_tx_bit_timer: cycle-count prescaler producing one bit_done pulse on the
// final cycle of every bit period.
//   rclk     : clock
//   rrst_n   : async active-low reset
//   load     : restarts the period (frame load)
//   prescale : cycles per bit, latched by the caller; 0 behaves as 1
//   bit_done : high on the last cycle of each bit period
module uart_tx_bit_timer #(
   parameter int PRESC_W = 8
) (
   input  logic               rclk,
   input  logic               rrst_n,
   input  logic               load,
   input  logic [PRESC_W-1:0] prescale,
   output logic               bit_done
);
   logic [PRESC_W-1:0] cnt;
   logic [PRESC_W-1:0] last;
   assign last     = (prescale == '0) ? '0 : prescale - 1'b1;
   assign bit_done = (cnt == last);
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)               cnt <= '0;
      else if (load || bit_done) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an async FIFO read port and sends each one as a
// UART frame (start, WIDTH data bits LSB first, optional parity, one stop).
//   rclk/rrst_n      : clock and async active-low reset
//   rempty/rdata     : FIFO read side status and data
//   rinc             : FIFO pop strobe, one cycle per word
//   prescale         : rclk cycles per bit (0 behaves as 1), held per frame
//   par_en/par_typ   : parity enable and type (0 even, 1 odd), held per frame
//   tx_out           : registered serial line, idle high
//   busy             : high while a frame is in progress
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 8
) (
   input  logic               rclk,
   input  logic               rrst_n,
   input  logic               rempty,
   input  logic [WIDTH-1:0]   rdata,
   output logic               rinc,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               par_en,
   input  logic               par_typ,
   output logic               tx_out,
   output logic               busy
);
   localparam int BW = $clog2(WIDTH) + 1;
   state_t             state, nxt;
   logic [WIDTH-1:0]   sh, sh_d;
   logic [BW-1:0]      bit_cnt, bit_cnt_d;
   logic [PRESC_W-1:0] presc_q;
   logic               par_en_q, par_bit_q, bit_done, tx_d;
   uart_tx_bit_timer #(.PRESC_W(PRESC_W)) u_timer (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .load     (rinc),
      .prescale (presc_q),
      .bit_done (bit_done)
   );
   // popping on the last STOP cycle chains frames with no idle gap
   assign rinc = !rempty && (state == IDLE || (state == STOP && bit_done));
   assign busy = (state != IDLE);
   always_comb begin
      nxt       = state;
      sh_d      = sh;
      bit_cnt_d = bit_cnt;
      case (state)
         IDLE:    if (rinc) nxt = START;
         START:   if (bit_done) begin
            nxt       = DATA;
            bit_cnt_d = '0;
         end
         DATA:    if (bit_done) begin
            if (bit_cnt == BW'(WIDTH - 1)) nxt = par_en_q ? PARITY : STOP;
            else begin
               sh_d      = sh >> 1;
               bit_cnt_d = bit_cnt + 1'b1;
            end
         end
         PARITY:  if (bit_done) nxt = STOP;
         STOP:    if (bit_done) nxt = rinc ? START : IDLE;
         default: nxt = IDLE;
      endcase
      if (rinc) sh_d = rdata;
      // tx_out is registered, so it is driven from the state being entered
      tx_d = (nxt == START)  ? 1'b0 :
             (nxt == DATA)   ? sh_d[0] :
             (nxt == PARITY) ? par_bit_q : 1'b1;
   end
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state     <= IDLE;
         sh        <= '0;
         bit_cnt   <= '0;
         tx_out    <= 1'b1;
         presc_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state   <= nxt;
         sh      <= sh_d;
         bit_cnt <= bit_cnt_d;
         tx_out  <= tx_d;
         if (rinc) begin
            presc_q   <= prescale;
            par_en_q  <= par_en;
            par_bit_q <= parity_of(^rdata, par_typ);
         end
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a FIFO model and a
// per-cycle scoreboard of expected serial line values.
module tb_fifo_uart_tx;
   import fifo_uart_tx_pkg::*;
   localparam int WIDTH   = 8;
   localparam int PRESC_W = 8;
   logic               rclk = 1'b0;
   logic               rrst_n, rempty, rinc, par_en, par_typ, tx_out, busy;
   logic [WIDTH-1:0]   rdata;
   logic [PRESC_W-1:0] prescale;
   int                 n_chk = 0, n_fail = 0;
   int                 rinc_cnt = 0, rinc_busy = 0, run_len = 0, last_run = 0, frames_ended = 0;
   bit                 pop_pend = 1'b0;
   logic [WIDTH-1:0]   fifo_q[$];
   logic               exp_q[$];
   always #5 rclk = ~rclk;
   fifo_uart_tx #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .prescale (prescale),
      .par_en   (par_en),
      .par_typ  (par_typ),
      .tx_out   (tx_out),
      .busy     (busy)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   // queue a word in the FIFO model and its expected frame, using current settings
   task automatic push(input logic [WIDTH-1:0] w);
      int   p;
      logic b;
      p = (prescale == '0) ? 1 : int'(prescale);
      fifo_q.push_back(w);
      for (int i = 0; i < WIDTH + 2 + int'(par_en); i++) begin
         b = (i == 0)                  ? 1'b0 :
             (i <= WIDTH)              ? w[i-1] :
             (par_en && i == WIDTH+1)  ? (par_typ ^ (^w)) : 1'b1;
         repeat (p) exp_q.push_back(b);
      end
   endtask
   // one clock: FIFO model update at negedge, then sample and score 1ns later
   task automatic tick();
      @(negedge rclk);
      if (pop_pend) begin
         void'(fifo_q.pop_front());
         pop_pend = 1'b0;
      end
      rempty = (fifo_q.size() == 0);
      rdata  = rempty ? '0 : fifo_q[0];
      #1;
      if (rinc) begin
         rinc_cnt++;
         if (busy) rinc_busy++;
         pop_pend = 1'b1;
         check("rinc_while_empty", rempty, 0);
      end
      if (busy) begin
         run_len++;
         if (exp_q.size() == 0) check("exp_empty_while_busy", exp_q.size(), 1);
         else check("tx_bit", tx_out, exp_q.pop_front());
      end else begin
         if (run_len != 0) begin
            last_run = run_len;
            frames_ended++;
            run_len = 0;
         end
         check("tx_idle", tx_out, 1);
      end
   endtask
   task automatic wait_frame(input string tag, input int bound);
      int f0;
      int n;
      f0 = frames_ended;
      n  = 0;
      while (frames_ended == f0 && n < bound) begin
         tick();
         n++;
      end
      check(tag, frames_ended != f0, 1);
   endtask
   initial begin
      int r0, rb0, n;
      rrst_n   = 1'b0;
      prescale = 8'd4;
      par_en   = 1'b0;
      par_typ  = PAR_EVEN;
      rempty   = 1'b1;
      rdata    = '0;
      repeat (3) tick();
      check("rst_tx", tx_out, 1);
      check("rst_busy", busy, 0);
      check("rst_rinc", rinc, 0);
      rrst_n = 1'b1;
      repeat (100) tick();
      check("idle_no_rinc", rinc_cnt, 0);
      check("idle_busy", busy, 0);
      // single word, no parity
      push(8'hA5);
      tick();
      check("pop_rinc", rinc, 1);
      check("pop_busy_before", busy, 0);
      tick();
      check("start_busy", busy, 1);
      check("start_tx", tx_out, 0);
      wait_frame("a5_end", 200);
      check("a5_len", last_run, 40);
      check("a5_rinc", rinc_cnt, 1);
      check("a5_drained", exp_q.size(), 0);
      // even parity, par_typ flipped mid-frame
      repeat (5) tick();
      par_en  = 1'b1;
      par_typ = PAR_EVEN;
      push(8'hA5);
      repeat (30) tick();
      par_typ = PAR_ODD;
      wait_frame("par_even_end", 200);
      check("par_even_len", last_run, 44);
      // odd parity
      repeat (5) tick();
      push(8'hA5);
      wait_frame("par_odd_end", 200);
      check("par_odd_len", last_run, 44);
      check("par_drained", exp_q.size(), 0);
      // back-to-back burst
      repeat (5) tick();
      par_en   = 1'b0;
      prescale = 8'd2;
      r0       = rinc_cnt;
      rb0      = rinc_busy;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      wait_frame("burst_end", 400);
      check("burst_len", last_run, 60);
      check("burst_rinc", rinc_cnt - r0, 3);
      check("burst_rinc_in_stop", rinc_busy - rb0, 2);
      check("burst_drained", exp_q.size(), 0);
      // prescale 0 behaves as 1
      repeat (5) tick();
      prescale = 8'd0;
      push(8'h81);
      wait_frame("p0_end", 100);
      check("p0_len", last_run, 10);
      // reset in DATA bit 3 aborts the frame
      repeat (5) tick();
      prescale = 8'd4;
      push(8'h5A);
      n = 0;
      while (!busy && n < 50) begin
         tick();
         n++;
      end
      check("abort_busy_seen", busy, 1);
      repeat (17) tick();
      rrst_n = 1'b0;
      #1;
      check("abort_tx", tx_out, 1);
      check("abort_busy", busy, 0);
      exp_q.delete();
      repeat (2) tick();
      rrst_n = 1'b1;
      tick();
      push(8'hC3);
      wait_frame("after_abort_end", 200);
      check("after_abort_len", last_run, 40);
      check("after_abort_drained", exp_q.size(), 0);
      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "timeout");
   end
endmodule
